// File: rtl/e_cmd_issue_pkg.sv
// Shared definitions for the e_cmd_issue host command issue / response capture stage.
// Register map, STATUS bit positions, FSM state and response type encodings.
package e_cmd_issue_pkg;

    localparam logic [3:0] ADDR_ARG_LO = 4'd0;
    localparam logic [3:0] ADDR_ARG_HI = 4'd1;
    localparam logic [3:0] ADDR_CMD    = 4'd2;
    localparam logic [3:0] ADDR_STATUS = 4'd3;
    localparam logic [3:0] ADDR_INT_EN = 4'd4;
    localparam logic [3:0] ADDR_RESP0  = 4'd8;

    // Event vector bits 0..4 share positions with the STATUS bits they set.
    localparam int ST_COMPLETE  = 0;
    localparam int ST_TIMEOUT   = 1;
    localparam int ST_CRC       = 2;
    localparam int ST_END_ERR   = 3;
    localparam int ST_INDEX_ERR = 4;
    localparam int ST_OVERRUN   = 5;
    localparam int ST_BUSY      = 6;
    localparam int NUM_EVT      = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE     = 2'b00,
        RESP_R48      = 2'b01,
        RESP_R136     = 2'b10,
        RESP_R48_BUSY = 2'b11
    } resp_t;

endpackage

// File: rtl/e_cmd_issue_toggle_evt.sv
// Toggle-to-pulse detector: a one-cycle event whenever an input bit changes level.
// The shadow copy tracks the input during reset too, so no event appears on release.
module e_toggle_evt #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tog,
    output logic [WIDTH-1:0] evt
);

    logic [WIDTH-1:0] tog_r;

    // Shadow register follows the input every cycle, including while in reset.
    always_ff @(posedge clk) begin
        tog_r <= tog;
    end

    // Event is the difference between current and previous level, masked in reset.
    always_comb begin
        if (rst) begin
            evt = '0;
        end else begin
            evt = tog ^ tog_r;
        end
    end

endmodule

// File: rtl/e_cmd_issue.sv
// Host-facing command issue stage: command registers, start handshake with the
// command-line controller, sticky W1C interrupt status and an 8-word response buffer.
module e_cmd_issue
    import e_cmd_issue_pkg::*;
#(
    parameter int ISSUE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [3:0]  reg_addr,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        irq,
    output logic        send_cmd,
    output logic [5:0]  cmd_index,
    output logic [1:0]  resp_type,
    output logic [31:0] argu_data,
    output logic        cmd_crc_check,
    output logic        cmd_index_check,
    input  logic        cmd_active,
    input  logic        cmd_done,
    input  logic        timeout_error,
    input  logic        crc_error,
    input  logic        resp_end_error,
    input  logic        cmd_index_error,
    input  logic [2:0]  resp_addr,
    input  logic [15:0] resp_data,
    input  logic        write_resp
);

    localparam logic [7:0] ISSUE_LAST = 8'(ISSUE_TIMEOUT - 1);

    logic [15:0] arg_lo_r;
    logic [15:0] arg_hi_r;
    logic [5:0]  cmd_index_r;
    resp_t       resp_type_r;
    logic        crc_chk_r;
    logic        idx_chk_r;
    logic [5:0]  int_en_r;
    logic [5:0]  status_r;
    logic [5:0]  status_s;
    logic [5:0]  status_set_s;
    logic [5:0]  status_clr_s;
    state_t      state_r;
    state_t      state_s;
    logic [7:0]  issue_cnt_r;
    logic [7:0]  issue_cnt_s;
    logic        inact_r;
    logic        inact_s;
    logic        send_cmd_r;
    logic        irq_r;
    logic [15:0] rdata_r;
    logic [15:0] rdata_s;
    logic [15:0] resp_buf [0:7];
    logic [4:0]  evt_s;
    logic        wr_cmd_s;
    logic        wr_status_s;

    e_toggle_evt #(
        .WIDTH (NUM_EVT)
    ) u_toggle_evt (
        .clk (clk),
        .rst (rst),
        .tog ({cmd_index_error, resp_end_error, crc_error, timeout_error, cmd_done}),
        .evt (evt_s)
    );

    assign wr_cmd_s    = reg_wr && (reg_addr == ADDR_CMD);
    assign wr_status_s = reg_wr && (reg_addr == ADDR_STATUS);

    // Next-state logic; events only move the FSM out of ACTIVE, but always set status.
    always_comb begin
        state_s      = state_r;
        issue_cnt_s  = issue_cnt_r;
        inact_s      = inact_r;
        status_set_s = {1'b0, evt_s};
        case (state_r)
            S_IDLE: begin
                if (wr_cmd_s) begin
                    state_s     = S_ISSUE;
                    issue_cnt_s = 8'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cmd_active) begin
                    state_s = S_ACTIVE;
                    inact_s = 1'b0;
                end else if (issue_cnt_r == ISSUE_LAST) begin
                    state_s                  = S_IDLE;
                    status_set_s[ST_TIMEOUT] = 1'b1;
                end else begin
                    issue_cnt_s = issue_cnt_r + 8'd1;
                end
            end
            S_ACTIVE: begin
                if (evt_s[ST_COMPLETE] || evt_s[ST_TIMEOUT]) begin
                    state_s = S_IDLE;
                end else if (!cmd_active) begin
                    // Controller went idle without reporting: treat a 2-cycle gap as a timeout.
                    if (inact_r) begin
                        state_s                  = S_IDLE;
                        status_set_s[ST_TIMEOUT] = 1'b1;
                    end else begin
                        inact_s = 1'b1;
                    end
                end else begin
                    inact_s = 1'b0;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        if (wr_cmd_s && (state_r != S_IDLE)) begin
            status_set_s[ST_OVERRUN] = 1'b1;
        end else begin
            status_set_s[ST_OVERRUN] = 1'b0;
        end
    end

    // W1C clear applied first so a same-cycle set wins.
    always_comb begin
        if (wr_status_s) begin
            status_clr_s = reg_wdata[5:0];
        end else begin
            status_clr_s = 6'd0;
        end
        status_s = (status_r & ~status_clr_s) | status_set_s;
    end

    // Register read mux; reads never have side effects.
    always_comb begin
        rdata_s = 16'd0;
        case (reg_addr)
            ADDR_ARG_LO: rdata_s = arg_lo_r;
            ADDR_ARG_HI: rdata_s = arg_hi_r;
            ADDR_CMD:    rdata_s = {6'd0, idx_chk_r, crc_chk_r, resp_type_r, cmd_index_r};
            ADDR_STATUS: begin
                rdata_s[5:0]    = status_r;
                rdata_s[ST_BUSY] = (state_r != S_IDLE);
            end
            ADDR_INT_EN: rdata_s = {10'd0, int_en_r};
            default: begin
                if (reg_addr >= ADDR_RESP0) begin
                    rdata_s = resp_buf[reg_addr[2:0]];
                end else begin
                    rdata_s = 16'd0;
                end
            end
        endcase
    end

    // Control state, status, interrupt and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            issue_cnt_r <= 8'd0;
            inact_r     <= 1'b0;
            status_r    <= 6'd0;
            send_cmd_r  <= 1'b0;
            irq_r       <= 1'b0;
            rdata_r     <= 16'd0;
        end else begin
            state_r     <= state_s;
            issue_cnt_r <= issue_cnt_s;
            inact_r     <= inact_s;
            status_r    <= status_s;
            send_cmd_r  <= (state_s == S_ISSUE);
            irq_r       <= |(status_r & int_en_r);
            if (reg_rd) begin
                rdata_r <= rdata_s;
            end
        end
    end

    // Host-writable configuration; CMD fields only change when a command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            arg_lo_r    <= 16'd0;
            arg_hi_r    <= 16'd0;
            int_en_r    <= 6'd0;
            cmd_index_r <= 6'd0;
            resp_type_r <= RESP_NONE;
            crc_chk_r   <= 1'b0;
            idx_chk_r   <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (reg_addr)
                    ADDR_ARG_LO: arg_lo_r <= reg_wdata;
                    ADDR_ARG_HI: arg_hi_r <= reg_wdata;
                    ADDR_INT_EN: int_en_r <= reg_wdata[5:0];
                    default:     ;
                endcase
            end
            if (wr_cmd_s && (state_r == S_IDLE)) begin
                cmd_index_r <= reg_wdata[5:0];
                resp_type_r <= resp_t'(reg_wdata[7:6]);
                crc_chk_r   <= reg_wdata[8];
                idx_chk_r   <= reg_wdata[9];
            end
        end
    end

    // Response buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (write_resp) begin
            resp_buf[resp_addr] <= resp_data;
        end
    end

    assign reg_rdata       = rdata_r;
    assign irq             = irq_r;
    assign send_cmd        = send_cmd_r;
    assign cmd_index       = cmd_index_r;
    assign resp_type       = resp_type_r;
    assign argu_data       = {arg_hi_r, arg_lo_r};
    assign cmd_crc_check   = crc_chk_r;
    assign cmd_index_check = idx_chk_r;

endmodule

// File: tb/tb_e_cmd_issue.sv
// Scoreboard bench for e_cmd_issue: directed scenarios plus randomized command
// sequences checked against a behavioural model of the register/interrupt rules.
module tb_e_cmd_issue;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr, reg_rd, write_resp, cmd_active;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata, resp_data;
    logic [2:0]  resp_addr;
    logic        irq, send_cmd, cmd_crc_check, cmd_index_check;
    logic [5:0]  cmd_index;
    logic [1:0]  resp_type;
    logic [31:0] argu_data;
    logic [4:0]  tog;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e_cmd_issue #(.ISSUE_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq), .send_cmd(send_cmd),
        .cmd_index(cmd_index), .resp_type(resp_type), .argu_data(argu_data),
        .cmd_crc_check(cmd_crc_check), .cmd_index_check(cmd_index_check),
        .cmd_active(cmd_active), .cmd_done(tog[0]), .timeout_error(tog[1]),
        .crc_error(tog[2]), .resp_end_error(tog[3]), .cmd_index_error(tog[4]),
        .resp_addr(resp_addr), .resp_data(resp_data), .write_resp(write_resp)
    );

    // Behavioural model: phase 0 idle, 1 issuing, 2 controller active.
    logic [31:0] m_arg;
    logic [9:0]  m_cmd;
    logic [5:0]  m_status, m_inten;
    int          m_phase, m_icnt;
    bit          m_inact;
    logic        m_irq;
    logic [15:0] m_resp [8];
    logic [4:0]  tog_prev;
    logic [15:0] exp_q [$];
    bit          mon_en = 1'b0;
    logic        rd_d;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(logic [3:0] a);
        if (a >= 4'd8) return m_resp[a[2:0]];
        case (a)
            4'd0:    return m_arg[15:0];
            4'd1:    return m_arg[31:16];
            4'd2:    return {6'd0, m_cmd};
            4'd3:    return {9'd0, (m_phase != 0), m_status};
            4'd4:    return {10'd0, m_inten};
            default: return 16'd0;
        endcase
    endfunction

    // One clock: queue any read expectation, then apply this cycle's inputs to the model.
    task automatic tick();
        logic [4:0] ev;
        logic [5:0] set, clr;
        int ph;
        if (reg_rd) exp_q.push_back(model_read(reg_addr));
        @(posedge clk);
        if (rst) begin
            m_arg = 32'd0; m_cmd = 10'd0; m_status = 6'd0; m_inten = 6'd0;
            m_phase = 0; m_icnt = 0; m_inact = 1'b0; m_irq = 1'b0;
        end else begin
            ev = tog ^ tog_prev;
            set = {1'b0, ev};
            clr = 6'd0;
            ph = m_phase;
            m_irq = |(m_status & m_inten);
            if (ph == 1) begin
                if (cmd_active) begin m_phase = 2; m_inact = 1'b0; end
                else if (m_icnt == T - 1) begin m_phase = 0; set[1] = 1'b1; end
                else m_icnt++;
            end else if (ph == 2) begin
                if (ev[0] || ev[1]) m_phase = 0;
                else if (!cmd_active) begin
                    if (m_inact) begin m_phase = 0; set[1] = 1'b1; end
                    else m_inact = 1'b1;
                end else m_inact = 1'b0;
            end
            if (reg_wr) begin
                case (reg_addr)
                    4'd0: m_arg[15:0] = reg_wdata;
                    4'd1: m_arg[31:16] = reg_wdata;
                    4'd2: if (ph != 0) set[5] = 1'b1;
                          else begin m_cmd = reg_wdata[9:0]; m_phase = 1; m_icnt = 0; end
                    4'd3: clr = reg_wdata[5:0];
                    4'd4: m_inten = reg_wdata[5:0];
                    default: ;
                endcase
            end
            m_status = (m_status & ~clr) | set;
            if (write_resp) m_resp[resp_addr] = resp_data;
        end
        tog_prev = tog;
        #1;
    endtask

    task automatic wr(logic [3:0] a, logic [15:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d; tick(); reg_wr = 1'b0;
    endtask

    task automatic rd(logic [3:0] a);
        reg_rd = 1'b1; reg_addr = a; tick(); reg_rd = 1'b0;
    endtask

    task automatic tgl(logic [4:0] m);
        tog = tog ^ m; tick();
    endtask

    task automatic go_active();
        cmd_active = 1'b1; tick();
    endtask

    // Monitor: outputs against the model, read data against the scoreboard queue.
    always @(posedge clk) rd_d <= reg_rd;

    always @(negedge clk) begin
        if (mon_en) begin
            check("send_cmd", send_cmd, (m_phase == 1));
            check("irq", irq, m_irq);
            check("argu_data", argu_data, m_arg);
            check("cmd_index", cmd_index, m_cmd[5:0]);
            check("resp_type", resp_type, m_cmd[7:6]);
            check("crc_check", cmd_crc_check, m_cmd[8]);
            check("index_check", cmd_index_check, m_cmd[9]);
            if (rd_d) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rdata: got 0x%0h with no read expected", reg_rdata);
                end else begin
                    check("rdata", reg_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, n, b;
        rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 4'd0; reg_wdata = 16'd0;
        cmd_active = 1'b0; tog = 5'd0; tog_prev = 5'd0; write_resp = 1'b0;
        resp_addr = 3'd0; resp_data = 16'd0;
        tick(); tick();
        mon_en = 1'b1;
        rst = 1'b0;
        tick();
        rd(4'd3); rd(4'd2); rd(4'd4);

        // Issue with no response
        wr(4'd0, 16'h1234); wr(4'd1, 16'h0000);
        wr(4'd2, 16'h0000);
        check("send_cmd_rise", send_cmd, 1'b1);
        go_active();
        check("send_cmd_drop", send_cmd, 1'b0);
        tgl(5'b00001);
        cmd_active = 1'b0;
        rd(4'd3);
        check("complete_status", reg_rdata, 16'h0001);
        wr(4'd3, 16'h0001);

        // 136-bit response with interrupt
        wr(4'd4, 16'h0001);
        wr(4'd0, 16'($urandom)); wr(4'd1, 16'($urandom));
        wr(4'd2, 16'h0382);
        go_active();
        for (int k = 7; k >= 0; k--) begin
            write_resp = 1'b1; resp_addr = 3'(k); resp_data = 16'hA000 + 16'(k); tick();
        end
        write_resp = 1'b0;
        tgl(5'b00001);
        cmd_active = 1'b0;
        check("irq_latency", irq, 1'b0);
        tick();
        check("irq_set", irq, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rd(4'd8 + 4'(k));
            check("resp_word", reg_rdata, 16'hA000 + 16'(k));
        end
        wr(4'd3, 16'h0001);
        tick();
        check("irq_clear", irq, 1'b0);
        rd(4'd3);

        // Same-cycle host read and controller write of one word returns the old value
        write_resp = 1'b1; resp_addr = 3'd3; resp_data = 16'h5555;
        reg_rd = 1'b1; reg_addr = 4'd11; tick();
        write_resp = 1'b0; reg_rd = 1'b0;
        check("resp_read_old", reg_rdata, 16'hA003);
        rd(4'd11);
        check("resp_read_new", reg_rdata, 16'h5555);
        wr(4'd5, 16'hFFFF); rd(4'd5); rd(4'd7);

        // Errors during ACTIVE
        wr(4'd2, 16'h0041);
        go_active();
        tgl(5'b00100);
        rd(4'd3);
        tgl(5'b00010);
        cmd_active = 1'b0;
        rd(4'd3);
        check("error_status", reg_rdata, 16'h0006);
        tgl(5'b00001);
        rd(4'd3);
        wr(4'd3, 16'h003F);

        // Issue timeout
        wr(4'd2, 16'h0005);
        cnt = 0;
        for (int i = 0; i < 64 && send_cmd; i++) begin
            cnt++;
            tick();
        end
        check("issue_timeout_len", cnt, T);
        rd(4'd3);
        check("issue_timeout_status", reg_rdata, 16'h0002);
        wr(4'd3, 16'h003F);

        // Overrun and set-wins W1C
        wr(4'd2, 16'h0011);
        wr(4'd2, 16'h0022);
        rd(4'd2);
        check("overrun_cmd_kept", reg_rdata, 16'h0011);
        rd(4'd3);
        check("overrun_status", reg_rdata, 16'h0060);
        go_active();
        tgl(5'b00100);
        reg_wr = 1'b1; reg_addr = 4'd3; reg_wdata = 16'h0004; tog = tog ^ 5'b00100; tick();
        reg_wr = 1'b0;
        rd(4'd3);
        tgl(5'b00001);
        cmd_active = 1'b0;
        wr(4'd3, 16'h003F);

        // Randomized command sequences
        for (int it = 0; it < 150; it++) begin
            wr(4'd0, 16'($urandom)); wr(4'd1, 16'($urandom));
            rd(4'd0); rd(4'd1);
            wr(4'd4, 16'($urandom));
            wr(4'd2, 16'($urandom));
            rd(4'd2);
            if ($urandom_range(0, 3) == 0) wr(4'd2, 16'($urandom));
            repeat ($urandom_range(0, 4)) tick();
            go_active();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                write_resp = 1'($urandom_range(0, 1));
                resp_addr = 3'($urandom); resp_data = 16'($urandom);
                reg_rd = 1'($urandom_range(0, 1)); reg_addr = 4'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    b = $urandom_range(2, 4);
                    tog[b] = ~tog[b];
                end
                tick();
            end
            write_resp = 1'b0; reg_rd = 1'b0;
            case ($urandom_range(0, 2))
                0: tgl(5'b00001);
                1: tgl(5'b00010);
                default: begin cmd_active = 1'b0; tick(); tick(); end
            endcase
            cmd_active = 1'b0;
            tick();
            rd(4'd3);
            rd(4'd8 + 4'($urandom_range(0, 7)));
            wr(4'd3, 16'($urandom));
            rd(4'd3);
        end

        // Reset mid-ACTIVE with every toggle input high
        tgl(~tog);
        wr(4'd3, 16'h003F);
        wr(4'd4, 16'h003F);
        wr(4'd2, 16'h03FF);
        go_active();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; cmd_active = 1'b0; tick();
        check("rst_send_cmd", send_cmd, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_argu", argu_data, 32'd0);
        check("rst_index", cmd_index, 6'd0);
        tick();
        rd(4'd3);
        check("rst_status", reg_rdata, 16'h0000);
        rd(4'd2); rd(4'd4); rd(4'd11);
        tick(); tick();
        check("read_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_cmd_issue.md
Name: e_cmd_issue

Overview:
- Host-facing command issue and response capture stage, directly upstream and downstream of the SD command-line controller.
- Holds the command argument, index and response type in host-writable registers, and pulses the controller's start request.
- Converts the controller's toggle-style completion and error flags into sticky, write-1-to-clear interrupt status bits.
- Stores the 16-bit response words the controller writes into an 8-entry response buffer that the host can read.

Parameters:
ISSUE_TIMEOUT, 16, cycles to wait for cmd_active after send_cmd before aborting with a timeout (4..255)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
reg_wr  in  1  host register write strobe (single cycle)
reg_rd  in  1  host register read strobe
reg_addr  in  4  register address
reg_wdata  in  16  write data
reg_rdata  out  16  read data, registered, valid cycle after reg_rd
irq  out  1  level interrupt
send_cmd  out  1  start request to command controller
cmd_index  out  6  command index
resp_type  out  2  00 none, 01/10 48/136-bit, 11 48-bit+busy
argu_data  out  32  command argument
cmd_crc_check  out  1  enable response CRC check
cmd_index_check  out  1  enable response index check
cmd_active  in  1  controller not idle
cmd_done  in  1  toggle: command finished
timeout_error  in  1  toggle: response timeout or collision
crc_error  in  1  toggle: CRC error
resp_end_error  in  1  toggle: bad end bit
cmd_index_error  in  1  toggle: index mismatch
resp_addr  in  3  response word address
resp_data  in  16  response word
write_resp  in  1  response word write strobe

Behaviour:
- Register map:
  - 0 ARG_LO and 1 ARG_HI: R/W; drive argu_data[15:0] and argu_data[31:16].
  - 2 CMD: R/W. Bits [5:0] index, [7:6] resp_type, [8] crc_chk, [9] idx_chk; remaining bits read 0. A write while idle also starts a command.
  - 3 STATUS: bit0 complete, bit1 timeout, bit2 crc, bit3 end_err, bit4 index_err, bit5 overrun are sticky W1C. bit6 busy is read-only (state != IDLE).
  - 4 INT_EN: R/W, bits [5:0].
  - 8-15 RESP0..RESP7: read-only response buffer.
  - All other addresses read 0; writes to them are ignored.
- Reset values:
  - All registers, INT_EN, STATUS and reg_rdata are 0; send_cmd=0; irq=0.
  - The response buffer is not reset.
  - Each toggle input's shadow flop loads the current input value, so no event is reported out of reset.
- Toggle event decode: evt_x = x ^ x_q, where x_q <= x every cycle. Each event lasts exactly one cycle.
- State machine:
  - IDLE: a write to CMD latches the fields and moves to ISSUE, with send_cmd=1 from the next cycle.
  - ISSUE: send_cmd held 1 and a counter increments each cycle. If cmd_active=1, go to ACTIVE and send_cmd=0 in the same transition. If the counter reaches ISSUE_TIMEOUT-1, set STATUS.timeout and return to IDLE.
  - ACTIVE: leave to IDLE on evt_cmd_done (set complete) or on evt_timeout (set timeout). Also leave to IDLE if cmd_active=0 for 2 consecutive cycles with no event (set timeout).
  - Error events (crc, end_err, index_err) set their STATUS bit in any state without changing state.
- Write to CMD while state != IDLE: the write is ignored, STATUS.overrun is set, and the CMD fields stay unchanged.
- Writes to ARG_LO/ARG_HI are accepted in any state. The controller samples the argument while the command is being sent, so software writes them only when idle.
- W1C rule: a bit set by an event in the same cycle as its W1C write ends set (set wins).
- Response buffer:
  - On write_resp, buf[resp_addr] <= resp_data, in any state.
  - A host read of the same word in the same cycle returns the old value.
- irq = |(STATUS[5:0] & INT_EN[5:0]), registered (1-cycle latency from the status change).
- Reads have no side effects.
- rst asserted mid-command: return to IDLE, send_cmd=0, STATUS cleared. The controller is reset from the same source.

Decomposition:
- Shared package holds:
  - register address constants (ARG_LO..RESP0);
  - STATUS bit index constants;
  - state encoding (IDLE, ISSUE, ACTIVE);
  - resp_type encodings.
- One natural sub-module, e_toggle_evt: a parameterised-width toggle-to-pulse detector with reset-time shadow load. It is instantiated once with width 5.

Test Plan:
- Issue, no response: write ARG=0x0000_1234, then CMD=0x0000 (index 0, resp_type 00).
  - send_cmd asserts the cycle after the write and drops once cmd_active=1.
  - A cmd_done toggle sets STATUS=0x0001; busy returns to 0.
- 136-bit response: 8 write_resp strobes, addr 7..0, data 0xA000+addr, then a cmd_done toggle.
  - RESP0..RESP7 read 0xA000..0xA007.
  - With INT_EN=0x01, irq=1 one cycle after complete is set. W1C 0x0001 clears both STATUS and irq.
- Errors: during ACTIVE, toggle crc_error, then toggle timeout_error.
  - STATUS=0x0006 and the state is IDLE. cmd_done toggling later sets bit0 with no other effect.
- Issue timeout: hold cmd_active=0 after the CMD write.
  - send_cmd stays high exactly ISSUE_TIMEOUT cycles, then STATUS.timeout=1 and the state is IDLE.
- Overrun: write CMD=0x0011, then CMD=0x0022 while busy.
  - STATUS.overrun=1 and CMD reads back 0x0011. A W1C in the same cycle as a new crc toggle leaves bit2 set.
- Reset: assert rst mid-ACTIVE with toggle inputs at 1.
  - All outputs return to 0 and no event fires after reset release.
